// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU sequencer: FSM states, error codes
// and the bit offsets of the dimension fields inside a config word.
package tpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    PROCESS,
    SEND,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_A    = 2'b01;
  localparam logic [1:0] ERR_M    = 2'b10;
  localparam logic [1:0] ERR_N    = 2'b11;

  // Config word layout, MSB to LSB: {a-1, m-1, n-1}.
  function automatic int cfg_n_lsb();
    return 0;
  endfunction

  function automatic int cfg_m_lsb(input int nw);
    return nw;
  endfunction

  function automatic int cfg_a_lsb(input int mw, input int nw);
    return mw + nw;
  endfunction

endpackage

// File: rtl/tpu_seq_ctrl_nest_counter.sv
// Two-level index counter: inner counts to its limit, then wraps and bumps
// outer. Both wrap to zero together on the final beat.
module nest_counter #(
  parameter int OW = 16,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [OW-1:0] outer_lim,
  input  logic [IW-1:0] inner_lim,
  output logic [OW-1:0] outer,
  output logic [IW-1:0] inner,
  output logic          last
);

  logic inner_at_lim;
  logic outer_at_lim;

  assign inner_at_lim = (inner == inner_lim);
  assign outer_at_lim = (outer == outer_lim);
  assign last         = inner_at_lim && outer_at_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outer <= '0;
      inner <= '0;
    end else if (clear) begin
      outer <= '0;
      inner <= '0;
    end else if (inc) begin
      if (inner_at_lim) begin
        inner <= '0;
        outer <= outer_at_lim ? '0 : outer + OW'(1);
      end else begin
        inner <= inner + IW'(1);
      end
    end
  end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// TPU sequencer: takes a dimension word, loads A and B under valid/ready,
// steps the systolic array, then drains the result through the PISO.
module tpu_seq_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int A_MAX = 60000,
  parameter int M_MAX = 256,
  parameter int N_MAX = 256,
  parameter int AW    = 16,
  parameter int MW    = 8,
  parameter int NW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] selA_a,
  output logic [NW-1:0] selA_n,
  output logic          wr_A,
  output logic          en_A,
  output logic [AW-1:0] selB_a,
  output logic [MW-1:0] selB_m,
  output logic          wr_B,
  output logic          en_B,
  output logic          proc_active,
  output logic          send,
  output logic [NW-1:0] selO_n,
  output logic [MW-1:0] selO_m
);

  localparam int A_LSB = cfg_a_lsb(MW, NW);
  localparam int M_LSB = cfg_m_lsb(NW);
  localparam int N_LSB = cfg_n_lsb();
  localparam int OW    = (AW > NW) ? AW : NW;
  localparam int IW    = (NW > MW) ? NW : MW;
  localparam int KW    = AW + 2;

  state_e        state, next_state;
  logic [AW-1:0] a_lim, a_fld;
  logic [MW-1:0] m_lim, m_fld;
  logic [NW-1:0] n_lim, n_fld;
  logic          a_bad, m_bad, n_bad, cfg_bad, cfg_take;
  logic [1:0]    cfg_code;
  logic [KW-1:0] step, proc_lim;
  logic          cnt_clear, cnt_inc, cnt_last;
  logic [OW-1:0] cnt_outer, outer_lim;
  logic [IW-1:0] cnt_inner, inner_lim;

  assign a_fld = in_data[A_LSB +: AW];
  assign m_fld = in_data[M_LSB +: MW];
  assign n_fld = in_data[N_LSB +: NW];

  assign a_bad   = (int'(a_fld) + 1) > A_MAX;
  assign m_bad   = (int'(m_fld) + 1) > M_MAX;
  assign n_bad   = (int'(n_fld) + 1) > N_MAX;
  assign cfg_bad = a_bad || m_bad || n_bad;
  assign cfg_code = a_bad ? ERR_A : m_bad ? ERR_M : n_bad ? ERR_N : ERR_NONE;

  assign cfg_take = (state == IDLE) && start && in_valid;
  assign busy     = (state != IDLE);
  assign proc_lim = KW'(a_lim) + KW'(m_lim) + KW'(n_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Error flags are sticky across IDLE and only clear on a legal config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lim    <= '0;
      m_lim    <= '0;
      n_lim    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (cfg_take) begin
      a_lim    <= a_fld;
      m_lim    <= m_fld;
      n_lim    <= n_fld;
      err      <= cfg_bad;
      err_code <= cfg_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (state == PROCESS && next_state == PROCESS) begin
      step <= step + KW'(1);
    end else begin
      step <= '0;
    end
  end

  // One nested counter serves both loads and the result drain.
  assign cnt_clear = abort || !(state == LOAD_A || state == LOAD_B || state == SEND);

  nest_counter #(
    .OW(OW),
    .IW(IW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .outer_lim(outer_lim),
    .inner_lim(inner_lim),
    .outer    (cnt_outer),
    .inner    (cnt_inner),
    .last     (cnt_last)
  );

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    done        = 1'b0;
    selA_a      = '0;
    selA_n      = '0;
    wr_A        = 1'b0;
    en_A        = 1'b0;
    selB_a      = '0;
    selB_m      = '0;
    wr_B        = 1'b0;
    en_B        = 1'b0;
    proc_active = 1'b0;
    send        = 1'b0;
    selO_n      = '0;
    selO_m      = '0;
    outer_lim   = OW'(a_lim);
    inner_lim   = IW'(n_lim);
    cnt_inc     = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start && in_valid) next_state = cfg_bad ? ERROR : LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        en_A     = in_valid;
        wr_A     = in_valid;
        selA_a   = cnt_outer[AW-1:0];
        selA_n   = cnt_inner[NW-1:0];
        cnt_inc  = in_valid;
        if (in_valid && cnt_last) next_state = LOAD_B;
      end
      LOAD_B: begin
        in_ready  = 1'b1;
        inner_lim = IW'(m_lim);
        en_B      = in_valid;
        wr_B      = in_valid;
        selB_a    = cnt_outer[AW-1:0];
        selB_m    = cnt_inner[MW-1:0];
        cnt_inc   = in_valid;
        if (in_valid && cnt_last) next_state = PROCESS;
      end
      PROCESS: begin
        proc_active = 1'b1;
        en_A        = 1'b1;
        en_B        = 1'b1;
        if (step <= KW'(a_lim)) begin
          selA_a = step[AW-1:0];
          selB_a = step[AW-1:0];
        end
        if (step == proc_lim) next_state = SEND;
      end
      SEND: begin
        outer_lim = OW'(n_lim);
        inner_lim = IW'(m_lim);
        send      = 1'b1;
        selO_n    = cnt_outer[NW-1:0];
        selO_m    = cnt_inner[MW-1:0];
        cnt_inc   = out_ready;
        if (out_ready && cnt_last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      ERROR: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    if (abort && state != IDLE) next_state = IDLE;
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: nominal run, stalls, errors, abort,
// asynchronous reset and the 1x1x1 corner.
module tb_tpu_seq_ctrl;
  import tpu_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int MW = 8;
  localparam int NW = 8;
  localparam int DW = 32;
  localparam logic [DW-1:0] CFG_NOM = 32'h0001_0102;

  logic          clk, rst_n, start, abort, in_valid, in_ready, out_ready;
  logic [DW-1:0] in_data;
  logic          err, busy, done, wr_A, en_A, wr_B, en_B, proc_active, send;
  logic [1:0]    err_code;
  logic [AW-1:0] selA_a, selB_a;
  logic [NW-1:0] selA_n, selO_n;
  logic [MW-1:0] selB_m, selO_m;

  int tests_run = 0;
  int tests_failed = 0;

  typedef int q_t[$];
  q_t a_log, b_log, o_log, a_stall_log, o_stall_log;
  int proc_cnt, done_cnt, stall_strobes, stall_send_low;
  bit run_timeout;

  tpu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .err(err), .err_code(err_code), .busy(busy),
    .done(done), .selA_a(selA_a), .selA_n(selA_n), .wr_A(wr_A), .en_A(en_A),
    .selB_a(selB_a), .selB_m(selB_m), .wr_B(wr_B), .en_B(en_B),
    .proc_active(proc_active), .send(send), .selO_n(selO_n), .selO_m(selO_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected row-major address list, encoded as outer*256 + inner.
  function automatic q_t seq(input int no, input int ni);
    q_t q;
    for (int o = 0; o < no; o++)
      for (int i = 0; i < ni; i++) q.push_back(o * 256 + i);
    return q;
  endfunction

  function automatic q_t rep(input int v, input int cnt);
    q_t q;
    for (int i = 0; i < cnt; i++) q.push_back(v);
    return q;
  endfunction

  function automatic int first_diff(input q_t got, input q_t exp);
    if (got.size() != exp.size()) return -2;
    foreach (got[i]) if (got[i] != exp[i]) return i;
    return -1;
  endfunction

  task automatic do_run(input logic [DW-1:0] cfg, input int a_stall_after, input int a_stall_len,
                        input int o_stall_at, input int o_stall_len);
    int a_beats, o_beats, a_left, o_left;
    bit o_armed, seen_done;
    a_beats = 0; o_beats = 0; a_left = 0; o_left = 0; o_armed = 1; seen_done = 0;
    a_log.delete(); b_log.delete(); o_log.delete(); a_stall_log.delete(); o_stall_log.delete();
    proc_cnt = 0; done_cnt = 0; stall_strobes = 0; stall_send_low = 0; run_timeout = 1;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = cfg; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (o_armed && o_stall_len > 0 && send && o_beats == o_stall_at - 1) begin
        o_left = o_stall_len;
        o_armed = 0;
      end
      in_valid  = (a_left == 0);
      out_ready = (o_left == 0);
      in_data   = $urandom;
      #1;
      if (en_A && wr_A) begin
        a_log.push_back(int'(selA_a) * 256 + int'(selA_n));
        a_beats++;
      end
      if (en_B && wr_B) b_log.push_back(int'(selB_a) * 256 + int'(selB_m));
      if (proc_active) proc_cnt++;
      if (send && out_ready) begin
        o_log.push_back(int'(selO_n) * 256 + int'(selO_m));
        o_beats++;
      end
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (a_left > 0) begin
        a_stall_log.push_back(int'(selA_a) * 256 + int'(selA_n));
        if (wr_A || en_A || wr_B || en_B) stall_strobes++;
      end
      if (o_left > 0) begin
        o_stall_log.push_back(int'(selO_n) * 256 + int'(selO_m));
        if (!send) stall_send_low++;
      end
      if (a_left > 0) a_left--;
      else if (en_A && wr_A && a_beats == a_stall_after) a_left = a_stall_len;
      if (o_left > 0) o_left--;
      @(negedge clk);
      if (seen_done && !busy) begin
        run_timeout = 0;
        break;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++;
    if ({busy, done, err, err_code} !== 5'b0) begin
      tests_failed++; $display("[TB] FAIL reset_status: got %b expected 00000", {busy, done, err, err_code});
    end
    tests_run++;
    if ({wr_A, en_A, wr_B, en_B, proc_active, send} !== 6'b0) begin
      tests_failed++; $display("[TB] FAIL reset_strobes: got %b expected 000000", {wr_A, en_A, wr_B, en_B, proc_active, send});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dut.state !== IDLE) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
  endtask

  task automatic test_nominal();
    int d;
    do_run(CFG_NOM, 0, 0, 0, 0);
    tests_run++;
    if (run_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL nom_timeout: got %b expected 0", run_timeout); end
    d = first_diff(a_log, seq(2, 3));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL nom_a_writes: got diff at %0d (size %0d) expected 6 in order", d, a_log.size()); end
    d = first_diff(b_log, seq(2, 2));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL nom_b_writes: got diff at %0d (size %0d) expected 4 in order", d, b_log.size()); end
    tests_run++;
    if (proc_cnt != 5) begin tests_failed++; $display("[TB] FAIL nom_proc_cycles: got %0d expected 5", proc_cnt); end
    d = first_diff(o_log, seq(3, 2));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL nom_send_beats: got diff at %0d (size %0d) expected 6 in order", d, o_log.size()); end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL nom_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int d;
    do_run(CFG_NOM, 2, 3, 3, 2);
    tests_run++;
    if (run_timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_timeout: got %b expected 0", run_timeout); end
    d = first_diff(a_log, seq(2, 3));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL bp_a_writes: got diff at %0d (size %0d) expected 6 in order", d, a_log.size()); end
    d = first_diff(b_log, seq(2, 2));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL bp_b_writes: got diff at %0d (size %0d) expected 4 in order", d, b_log.size()); end
    tests_run++;
    if (stall_strobes != 0) begin tests_failed++; $display("[TB] FAIL bp_stall_strobes: got %0d expected 0", stall_strobes); end
    d = first_diff(a_stall_log, rep(2, 3));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL bp_a_frozen: got diff at %0d (size %0d) expected 3 x addr (0,2)", d, a_stall_log.size()); end
    d = first_diff(o_stall_log, rep(256, 2));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL bp_o_frozen: got diff at %0d (size %0d) expected 2 x addr (1,0)", d, o_stall_log.size()); end
    tests_run++;
    if (stall_send_low != 0) begin tests_failed++; $display("[TB] FAIL bp_send_held: got %0d low cycles expected 0", stall_send_low); end
    d = first_diff(o_log, seq(3, 2));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL bp_send_beats: got diff at %0d (size %0d) expected 6 in order", d, o_log.size()); end
    tests_run++;
    if (proc_cnt != 5) begin tests_failed++; $display("[TB] FAIL bp_proc_cycles: got %0d expected 5", proc_cnt); end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL bp_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_error();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 32'hEA60_0000;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (dut.state !== ERROR) begin tests_failed++; $display("[TB] FAIL err_state: got %0d expected %0d", dut.state, ERROR); end
    tests_run++;
    if ({err, err_code} !== 3'b101) begin tests_failed++; $display("[TB] FAIL err_code_a: got %b expected 101", {err, err_code}); end
    tests_run++;
    if ({busy, in_ready, wr_A} !== 3'b100) begin tests_failed++; $display("[TB] FAIL err_busy: got %b expected 100", {busy, in_ready, wr_A}); end
    @(negedge clk);
    tests_run++;
    if (dut.state !== IDLE) begin tests_failed++; $display("[TB] FAIL err_to_idle: got %0d expected %0d", dut.state, IDLE); end
    tests_run++;
    if ({err, err_code} !== 3'b101) begin tests_failed++; $display("[TB] FAIL err_sticky: got %b expected 101", {err, err_code}); end
    start = 1'b1; in_valid = 1'b1; in_data = 32'h0000_FF00;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (dut.state !== LOAD_A) begin tests_failed++; $display("[TB] FAIL err_legal_state: got %0d expected %0d", dut.state, LOAD_A); end
    tests_run++;
    if ({err, err_code} !== 3'b000) begin tests_failed++; $display("[TB] FAIL err_cleared: got %b expected 000", {err, err_code}); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_cleanup_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort();
    bit saw_done;
    int d;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = CFG_NOM; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (dut.state !== LOAD_A) begin tests_failed++; $display("[TB] FAIL abort_idle_ignored: got %0d expected %0d", dut.state, LOAD_A); end
    repeat (8) @(negedge clk);
    tests_run++;
    if (dut.state !== LOAD_B) begin tests_failed++; $display("[TB] FAIL abort_in_load_b: got %0d expected %0d", dut.state, LOAD_B); end
    in_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b00 || dut.state !== IDLE) begin
      tests_failed++; $display("[TB] FAIL abort_load_b: got busy/done %b state %0d expected 00 state %0d", {busy, done}, dut.state, IDLE);
    end
    tests_run++;
    if ({dut.u_cnt.outer, dut.u_cnt.inner} !== '0) begin
      tests_failed++; $display("[TB] FAIL abort_cnt_clear: got %0d/%0d expected 0/0", dut.u_cnt.outer, dut.u_cnt.inner);
    end
    start = 1'b1; in_valid = 1'b1; in_data = CFG_NOM;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && dut.state !== SEND; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    tests_run++;
    if (dut.state !== SEND) begin tests_failed++; $display("[TB] FAIL abort_reach_send: got %0d expected %0d", dut.state, SEND); end
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    if (done) saw_done = 1;
    tests_run++;
    if ({busy, send} !== 2'b00 || dut.state !== IDLE) begin
      tests_failed++; $display("[TB] FAIL abort_send: got busy/send %b state %0d expected 00 state %0d", {busy, send}, dut.state, IDLE);
    end
    tests_run++;
    if (saw_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done); end
    do_run(CFG_NOM, 0, 0, 0, 0);
    d = first_diff(o_log, seq(3, 2));
    tests_run++;
    if (d != -1 || done_cnt != 1 || run_timeout) begin
      tests_failed++; $display("[TB] FAIL abort_rerun: got diff %0d done %0d timeout %b expected -1 1 0", d, done_cnt, run_timeout);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = CFG_NOM;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30 && dut.state !== PROCESS; i++) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (proc_active !== 1'b1) begin tests_failed++; $display("[TB] FAIL areset_in_process: got %b expected 1", proc_active); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, proc_active, en_A, en_B, wr_A, wr_B, send, done, err} !== 9'b0) begin
      tests_failed++; $display("[TB] FAIL areset_outputs: got %b expected 000000000", {busy, proc_active, en_A, en_B, wr_A, wr_B, send, done, err});
    end
    tests_run++;
    if ({selA_a, selB_a, selA_n, selB_m, selO_n, selO_m} !== '0) begin
      tests_failed++; $display("[TB] FAIL areset_selects: got %0h expected 0", {selA_a, selB_a, selA_n, selB_m, selO_n, selO_m});
    end
    tests_run++;
    if (in_ready !== 1'b1 || dut.state !== IDLE) begin
      tests_failed++; $display("[TB] FAIL areset_idle: got in_ready %b state %0d expected 1 state %0d", in_ready, dut.state, IDLE);
    end
    #4 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_stays_idle: got %b expected 0", busy); end
  endtask

  task automatic test_min_size();
    int d;
    do_run(32'h0000_0000, 0, 0, 0, 0);
    d = first_diff(a_log, seq(1, 1));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL min_a_write: got diff at %0d (size %0d) expected 1 at (0,0)", d, a_log.size()); end
    d = first_diff(b_log, seq(1, 1));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL min_b_write: got diff at %0d (size %0d) expected 1 at (0,0)", d, b_log.size()); end
    tests_run++;
    if (proc_cnt != 1) begin tests_failed++; $display("[TB] FAIL min_proc_cycles: got %0d expected 1", proc_cnt); end
    d = first_diff(o_log, seq(1, 1));
    tests_run++;
    if (d != -1) begin tests_failed++; $display("[TB] FAIL min_send_beat: got diff at %0d (size %0d) expected 1 at (0,0)", d, o_log.size()); end
    tests_run++;
    if (done_cnt != 1 || run_timeout) begin
      tests_failed++; $display("[TB] FAIL min_done: got %0d timeout %b expected 1 0", done_cnt, run_timeout);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_error();
    test_abort();
    test_async_reset();
    test_min_size();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
- Second-generation sequencer for the parameterised TPU datapath.
- Accepts one dimension word, then streams matrix A (a×n) and matrix B (a×m) into the operand buffers under valid/ready flow control.
- Runs the systolic array for a+n+m-2 cycles, then drains the n×m result through the PISO with out_ready backpressure.
- Generalises field widths and adds real handshakes, error codes, abort and a done pulse.

Parameters:
- A_MAX, 60000, largest legal a dimension.
- M_MAX, 256, largest legal m dimension.
- N_MAX, 256, largest legal n dimension.
- AW, 16, width of the a index; must satisfy 2^AW >= A_MAX.
- MW, 8, width of the m index.
- NW, 8, width of the n index.
- DW, 32, input data width; must satisfy DW >= AW+MW+NW.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  qualifies a config word in IDLE
- abort  in  1  synchronous abort to IDLE
- in_valid  in  1  in_data valid
- in_data  in  DW  config word or matrix element
- in_ready  out  1  controller accepts in_data
- out_ready  in  1  PISO accepts a result beat
- err  out  1  sticky configuration error
- err_code  out  2  01 = a bad, 10 = m bad, 11 = n bad
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- selA_a  out  AW  buffer A row address
- selA_n  out  NW  buffer A column address
- wr_A  out  1  buffer A write
- en_A  out  1  buffer A enable
- selB_a  out  AW  buffer B row address
- selB_m  out  MW  buffer B column address
- wr_B  out  1  buffer B write
- en_B  out  1  buffer B enable
- proc_active  out  1  array compute cycle
- send  out  1  PISO beat valid
- selO_n  out  NW  result row
- selO_m  out  MW  result column

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; err=0, err_code=0, done=0, busy=0; all counters 0; all select, strobe and send outputs 0; in_ready=1 because it is decoded from IDLE.
- Config word fields hold dimension minus 1:
  - a-1 = in_data[AW+MW+NW-1 : MW+NW]
  - m-1 = in_data[MW+NW-1 : NW]
  - n-1 = in_data[NW-1 : 0]
  - A field is illegal when field+1 > its MAX.
- IDLE:
  - in_ready=1.
  - On start && in_valid, latch the fields.
  - Any field illegal → ERROR; err_code priority is a > m > n.
  - Otherwise → LOAD_A, clear err and err_code, counters cleared.
- LOAD_A:
  - in_ready=1.
  - Each accepted beat (in_valid && in_ready) drives en_A=wr_A=1 in the same cycle with selA_a=outer, selA_n=inner.
  - Inner index is n, counting 0..n-1; outer index is a.
  - No beat means no counter change and no strobe; this is the pause behaviour.
  - The last beat (a-1, n-1) → LOAD_B.
- LOAD_B: same as LOAD_A with inner index m, strobes en_B/wr_B, addresses selB_a/selB_m. The last beat → PROCESS.
- PROCESS:
  - in_ready=0, proc_active=1, en_A=en_B=1, wr_A=wr_B=0.
  - Step k counts 0..a+n+m-3.
  - selA_a=selB_a=k while k<a, else 0.
  - After the final step → SEND; an a=n=m=1 run lasts exactly 1 cycle.
- SEND:
  - send=1, selO_n=outer, selO_m=inner (m inner).
  - Indices advance only on out_ready; selects hold stable while out_ready=0.
  - The last accepted beat → DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: one cycle, then IDLE. err and err_code stay set until the next legal config is accepted.
- abort:
  - Sampled high in any state other than IDLE → IDLE next cycle, counters cleared, no done pulse, err unchanged.
  - abort takes priority over all other transitions.
  - abort in IDLE is ignored; a config word in that cycle is still taken.
- busy = (state != IDLE), so it is 1 in LOAD_A, LOAD_B, PROCESS, SEND, DONE and ERROR.
- Index arithmetic is unsigned, with compare-to-limit wrap: inner wraps to 0 and outer increments. There is no overflow past the latched limits.
- The step counter is AW+2 bits wide.

Decomposition:
- Package tpu_ctrl_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, PROCESS, SEND, DONE, ERROR);
  - the err_code localparams;
  - config-field offset constants derived from AW/MW/NW.
- Sub-module nest_counter:
  - parameterised outer/inner widths;
  - inputs: clear, inc, outer_lim, inner_lim;
  - outputs: outer, inner, last (both at their limits).
  - Instantiated once and reused by LOAD_A, LOAD_B and SEND.
- The PROCESS step counter is a separate flat counter.

Test Plan:
- Nominal run with config 0x0001_0102 (a=2, m=2, n=3) and continuous valid, out_ready=1 → expect:
  - 6 A writes, addresses (0,0)..(1,2);
  - 4 B writes;
  - proc_active for exactly 5 cycles;
  - 6 send beats, (0,0)..(2,1);
  - done high for 1 cycle.
- Backpressure: same run with in_valid low 3 cycles after the 2nd A beat and out_ready low 2 cycles at SEND beat 3 → no strobes and frozen selects during the stalls; identical address sequence; done still pulses once.
- Errors:
  - a field = 60000 (a=60001) → err=1, err_code=01, LOAD_A never entered.
  - Then config with m field 0xFF and n field 0x00 (legal) → err clears on acceptance.
- Abort: abort high mid-LOAD_B and again mid-SEND → IDLE next cycle, busy=0, no done; a following legal run completes normally.
- Async reset: rst_n low for half a cycle during PROCESS → all outputs 0 immediately, in_ready=1, state IDLE.
- Minimum size: config 0x0000_0000 (a=m=n=1) → 1 A write, 1 B write, 1 PROCESS cycle, 1 send beat at (0,0), done.
